// File: rtl/l2_arb_pkg.sv
// Shared constants for the L2 port arbiter: default parameters, FSM state
// encoding and a clog2 helper used to size the round-robin pointer.
package l2_arb_pkg;

  localparam int DEF_NUM_CORES  = 2;
  localparam int DEF_TAG_WIDTH  = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_L2_LATENCY = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_RESP  = ST_RESP
  } state_e;

  // ceil(log2(n)), minimum 1 so a pointer always has at least one bit
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/l2_port_arbiter_rr_pick.sv
// Round-robin picker: one-hot of the first requester at or after rr_ptr,
// wrapping to core 0. Pure combinational.
module rr_pick
  import l2_arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int PTR_W     = clog2(DEF_NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic [NUM_CORES-1:0] pick
);

  localparam logic [NUM_CORES-1:0] ONE = NUM_CORES'(1);

  logic [NUM_CORES-1:0] mask_ge;
  logic [NUM_CORES-1:0] req_hi;
  logic [NUM_CORES-1:0] src;

  // Prefer requesters at/above the pointer; otherwise wrap to the lowest one.
  // x & (~x + 1) isolates the lowest set bit.
  always_comb begin
    mask_ge = ~((ONE << rr_ptr) - ONE);
    req_hi  = req & mask_ge;
    src     = (|req_hi) ? req_hi : req;
    pick    = src & (~src + ONE);
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// L2 port arbiter: round-robin grants one core at a time onto a single L2 read
// port, issues a one-cycle read strobe, waits L2_LATENCY cycles, and returns
// the data with a one-hot response strobe.
// Optional: define L2_ARB_STATS_EN to add saturating txn_count / miss_count.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int NUM_CORES  = DEF_NUM_CORES,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int L2_LATENCY = DEF_L2_LATENCY
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CORES-1:0]           req,
  input  logic [NUM_CORES*TAG_WIDTH-1:0] addr,
  output logic [NUM_CORES-1:0]           grant,
  output logic                           l2_en,
  output logic [TAG_WIDTH-1:0]           l2_addr,
  input  logic [DATA_WIDTH-1:0]          l2_data,
  input  logic                           l2_hit,
  output logic [NUM_CORES-1:0]           rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           rsp_hit,
  output logic                           busy
`ifdef L2_ARB_STATS_EN
  ,
  output logic [15:0]                    txn_count,
  output logic [15:0]                    miss_count
`endif
);

  localparam int PTR_W  = clog2(NUM_CORES);
  localparam int WCNT_W = 4;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(L2_LATENCY - 1);

  state_e                  state_q, state_d;
  logic [NUM_CORES-1:0]    grant_q, grant_d;
  logic                    l2_en_q, l2_en_d;
  logic [TAG_WIDTH-1:0]    l2_addr_q, l2_addr_d;
  logic [NUM_CORES-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_hit_q, rsp_hit_d;
  logic                    busy_q, busy_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [WCNT_W-1:0]       wait_cnt_q, wait_cnt_d;

  logic [NUM_CORES-1:0]    pick;
  logic [TAG_WIDTH-1:0]    sel_addr;
  logic [PTR_W-1:0]        gidx;
  logic [PTR_W-1:0]        ptr_next;

`ifdef L2_ARB_STATS_EN
  logic [15:0] txn_count_q, txn_count_d;
  logic [15:0] miss_count_q, miss_count_d;
`endif

  rr_pick #(
    .NUM_CORES (NUM_CORES),
    .PTR_W     (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick)
  );

  // Mux the winner's address; pick is one-hot so an OR-reduce suffices
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (pick[i]) sel_addr = sel_addr | addr[i*TAG_WIDTH +: TAG_WIDTH];
  end

  // Encode the held grant to an index and derive the next round-robin start
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (grant_q[i]) gidx = PTR_W'(i);
    ptr_next = (gidx == PTR_W'(NUM_CORES - 1)) ? '0 : gidx + PTR_W'(1);
  end

  // FSM next-state and registered-output logic; req/addr only matter in IDLE
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    l2_en_d     = 1'b0;
    l2_addr_d   = l2_addr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_hit_d   = rsp_hit_q;
    rr_ptr_d    = rr_ptr_q;
    wait_cnt_d  = wait_cnt_q;
`ifdef L2_ARB_STATS_EN
    txn_count_d  = txn_count_q;
    miss_count_d = miss_count_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d   = S_ISSUE;
          grant_d   = pick;
          l2_addr_d = sel_addr;
          l2_en_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d     = S_RESP;
          rsp_data_d  = l2_data;
          rsp_hit_d   = l2_hit;
          rsp_valid_d = grant_q;
`ifdef L2_ARB_STATS_EN
          if (txn_count_q != 16'hFFFF) txn_count_d = txn_count_q + 16'd1;
          if (!l2_hit && miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
`endif
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      S_RESP: begin
        state_d  = S_IDLE;
        grant_d  = '0;
        rr_ptr_d = ptr_next;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any in-flight transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      l2_en_q     <= 1'b0;
      l2_addr_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      busy_q      <= 1'b0;
      rr_ptr_q    <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      l2_en_q     <= l2_en_d;
      l2_addr_q   <= l2_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_hit_q   <= rsp_hit_d;
      busy_q      <= busy_d;
      rr_ptr_q    <= rr_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

`ifdef L2_ARB_STATS_EN
  // Saturating transaction / miss counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txn_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      txn_count_q  <= txn_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign txn_count  = txn_count_q;
  assign miss_count = miss_count_q;
`endif

  assign grant     = grant_q;
  assign l2_en     = l2_en_q;
  assign l2_addr   = l2_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_hit   = rsp_hit_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: a 2-core/latency-1 instance and a
// 4-core/latency-3 instance, each with a latency-accurate L2 model and a
// response scoreboard. Stats checks are built when L2_ARB_STATS_EN is defined.
module tb_l2_port_arbiter;

  localparam int NA = 2;
  localparam int LA = 1;
  localparam int NB = 4;
  localparam int LB = 3;
  localparam int TW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A signals
  logic              rst_a;
  logic [NA-1:0]     req_a;
  logic [NA*TW-1:0]  addr_a;
  logic [NA-1:0]     grant_a, rsp_valid_a;
  logic              l2_en_a, l2_hit_a, rsp_hit_a, busy_a;
  logic [TW-1:0]     l2_addr_a;
  logic [DW-1:0]     l2_data_a, rsp_data_a;
  // DUT B signals
  logic              rst_b;
  logic [NB-1:0]     req_b;
  logic [NB*TW-1:0]  addr_b;
  logic [NB-1:0]     grant_b, rsp_valid_b;
  logic              l2_en_b, l2_hit_b, rsp_hit_b, busy_b;
  logic [TW-1:0]     l2_addr_b;
  logic [DW-1:0]     l2_data_b, rsp_data_b;
`ifdef L2_ARB_STATS_EN
  logic [15:0] txn_a, miss_a, txn_b, miss_b;
`endif

  l2_port_arbiter #(.NUM_CORES(NA), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .L2_LATENCY(LA)) u_dut_a (
    .clk(clk), .reset(rst_a), .req(req_a), .addr(addr_a), .grant(grant_a),
    .l2_en(l2_en_a), .l2_addr(l2_addr_a), .l2_data(l2_data_a), .l2_hit(l2_hit_a),
    .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .rsp_hit(rsp_hit_a), .busy(busy_a)
`ifdef L2_ARB_STATS_EN
    , .txn_count(txn_a), .miss_count(miss_a)
`endif
  );

  l2_port_arbiter #(.NUM_CORES(NB), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .L2_LATENCY(LB)) u_dut_b (
    .clk(clk), .reset(rst_b), .req(req_b), .addr(addr_b), .grant(grant_b),
    .l2_en(l2_en_b), .l2_addr(l2_addr_b), .l2_data(l2_data_b), .l2_hit(l2_hit_b),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_hit(rsp_hit_b), .busy(busy_b)
`ifdef L2_ARB_STATS_EN
    , .txn_count(txn_b), .miss_count(miss_b)
`endif
  );

  function automatic logic [7:0] data_of(input logic [3:0] a);
    return {a, a} ^ 8'h96;
  endfunction

  function automatic logic hit_of(input logic [3:0] a);
    return a[0];
  endfunction

  // L2 model: data is valid only exactly L cycles after the strobe edge;
  // any other time it drives junk with an inverted hit.
  logic       en_pa [1:LA];
  logic [3:0] ad_pa [1:LA];
  logic       en_pb [1:LB];
  logic [3:0] ad_pb [1:LB];

  always @(posedge clk) begin
    en_pa[1] <= l2_en_a;
    ad_pa[1] <= l2_addr_a;
    for (int i = 2; i <= LA; i++) begin
      en_pa[i] <= en_pa[i-1];
      ad_pa[i] <= ad_pa[i-1];
    end
  end

  always @(posedge clk) begin
    en_pb[1] <= l2_en_b;
    ad_pb[1] <= l2_addr_b;
    for (int i = 2; i <= LB; i++) begin
      en_pb[i] <= en_pb[i-1];
      ad_pb[i] <= ad_pb[i-1];
    end
  end

  assign l2_data_a = (en_pa[LA] === 1'b1) ? data_of(ad_pa[LA]) : 8'hEE;
  assign l2_hit_a  = (en_pa[LA] === 1'b1) ? hit_of(ad_pa[LA]) : ~hit_of(ad_pa[LA]);
  assign l2_data_b = (en_pb[LB] === 1'b1) ? data_of(ad_pb[LB]) : 8'hEE;
  assign l2_hit_b  = (en_pb[LB] === 1'b1) ? hit_of(ad_pb[LB]) : ~hit_of(ad_pb[LB]);

  typedef struct {
    logic [7:0] vld;
    logic [7:0] data;
    logic       hit;
    int         at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // dly: cycles from now until the IDLE cycle that samples this request
  task automatic push_a(input logic [7:0] vld, input logic [3:0] a, input int dly);
    qa.push_back('{vld, data_of(a), hit_of(a), cyc + dly + 2 + LA});
  endtask

  task automatic push_b(input logic [7:0] vld, input logic [3:0] a, input int dly);
    qb.push_back('{vld, data_of(a), hit_of(a), cyc + dly + 2 + LB});
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Response monitors: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (rsp_valid_a !== '0) begin
      if (qa.size() == 0) chk("a_unexpected_rsp", 32'(rsp_valid_a), 32'd0);
      else begin
        ea = qa.pop_front();
        chk("a_rsp_valid", 32'(rsp_valid_a), 32'(ea.vld));
        chk("a_rsp_data",  32'(rsp_data_a),  32'(ea.data));
        chk("a_rsp_hit",   32'(rsp_hit_a),   32'(ea.hit));
        chk("a_rsp_cycle", cyc, ea.at);
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid_b !== '0) begin
      if (qb.size() == 0) chk("b_unexpected_rsp", 32'(rsp_valid_b), 32'd0);
      else begin
        eb = qb.pop_front();
        chk("b_rsp_valid", 32'(rsp_valid_b), 32'(eb.vld));
        chk("b_rsp_data",  32'(rsp_data_b),  32'(eb.data));
        chk("b_rsp_hit",   32'(rsp_hit_b),   32'(eb.hit));
        chk("b_rsp_cycle", cyc, eb.at);
      end
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    req_a = '0; addr_a = '0; req_b = '0; addr_b = '0;
    tick(2);
    // reset state
    chk("rst_grant",     32'(grant_a),     32'd0);
    chk("rst_l2_en",     32'(l2_en_a),     32'd0);
    chk("rst_l2_addr",   32'(l2_addr_a),   32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data_a),  32'd0);
    chk("rst_rsp_hit",   32'(rsp_hit_a),   32'd0);
    chk("rst_busy",      32'(busy_a),      32'd0);
    chk("rst_b_grant",   32'(grant_b),     32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // single request from core 0, addr 3
    addr_a = {4'h0, 4'h3}; req_a = 2'b01;
    push_a(8'h01, 4'h3, 0);
    tick();
    req_a = 2'b00;
    chk("t1_grant",   32'(grant_a),   32'h1);
    chk("t1_l2_en",   32'(l2_en_a),   32'd1);
    chk("t1_l2_addr", 32'(l2_addr_a), 32'h3);
    chk("t1_busy",    32'(busy_a),    32'd1);
    tick();
    chk("t1_wait_l2_en",  32'(l2_en_a),   32'd0);
    chk("t1_wait_l2_addr",32'(l2_addr_a), 32'h3);
    tick();
    chk("t1_resp_data", 32'(rsp_data_a), 32'hA5);
    tick();
    chk("t1_idle_grant", 32'(grant_a),     32'd0);
    chk("t1_idle_busy",  32'(busy_a),      32'd0);
    chk("t1_idle_rspv",  32'(rsp_valid_a), 32'd0);
    chk("t1_data_hold",  32'(rsp_data_a),  32'hA5);

    // both cores requesting continuously from a fresh pointer
    rst_a = 1'b1; tick(); rst_a = 1'b0; tick();
    addr_a = {4'h6, 4'h1}; req_a = 2'b11;
    push_a(8'h01, 4'h1, 0);
    push_a(8'h02, 4'h6, 4);
    push_a(8'h01, 4'h1, 8);
    tick();
    chk("t2_grant0", 32'(grant_a), 32'h1);
    tick(4);
    chk("t2_grant1", 32'(grant_a), 32'h2);
    tick(4);
    chk("t2_grant2", 32'(grant_a), 32'h1);
    req_a = 2'b00;
    tick(4);
    chk("t2_busy_end", 32'(busy_a), 32'd0);

    // core 0 drops req and changes addr mid-transaction (pointer now 1)
    addr_a = {4'h0, 4'h5}; req_a = 2'b01;
    push_a(8'h01, 4'h5, 0);
    tick();
    chk("t5_grant",   32'(grant_a),   32'h1);
    chk("t5_l2_addr", 32'(l2_addr_a), 32'h5);
    tick();
    req_a = 2'b00; addr_a = {4'h0, 4'h9};
    tick();
    chk("t5_l2_addr_resp", 32'(l2_addr_a), 32'h5);
    tick();
    chk("t5_l2_addr_idle", 32'(l2_addr_a), 32'h5);

    // reset during WAIT aborts the transaction
    addr_a = {4'h0, 4'h2}; req_a = 2'b01;
    tick();
    tick();
    rst_a = 1'b1;
    #1;
    chk("t4_grant",     32'(grant_a),     32'd0);
    chk("t4_l2_en",     32'(l2_en_a),     32'd0);
    chk("t4_l2_addr",   32'(l2_addr_a),   32'd0);
    chk("t4_rsp_valid", 32'(rsp_valid_a), 32'd0);
    chk("t4_rsp_data",  32'(rsp_data_a),  32'd0);
    chk("t4_rsp_hit",   32'(rsp_hit_a),   32'd0);
    chk("t4_busy",      32'(busy_a),      32'd0);
    req_a = 2'b00;
    tick(2);
    rst_a = 1'b0;
    tick();
    addr_a = {4'h7, 4'h4}; req_a = 2'b11;
    push_a(8'h01, 4'h4, 0);
    tick();
    chk("t4_first_grant", 32'(grant_a), 32'h1);
    req_a = 2'b00;
    tick(4);

`ifdef L2_ARB_STATS_EN
    rst_a = 1'b1; tick(); rst_a = 1'b0; tick();
    addr_a = {4'h0, 4'h1}; req_a = 2'b01; push_a(8'h01, 4'h1, 0); tick(); req_a = 2'b00; tick(4);
    addr_a = {4'h0, 4'h2}; req_a = 2'b01; push_a(8'h01, 4'h2, 0); tick(); req_a = 2'b00; tick(4);
    addr_a = {4'h0, 4'h4}; req_a = 2'b01; push_a(8'h01, 4'h4, 0); tick(); req_a = 2'b00; tick(4);
    chk("stats_txn",  32'(txn_a),  32'd3);
    chk("stats_miss", 32'(miss_a), 32'd2);
`endif

    // 4-core, latency 3: move pointer to 2 via a core-1 transaction
    addr_b = {4'h0, 4'h0, 4'hB, 4'h0}; req_b = 4'b0010;
    push_b(8'h02, 4'hB, 0);
    tick();
    chk("t3_pre_grant", 32'(grant_b), 32'h2);
    req_b = 4'b0000;
    tick(5);
    chk("t3_pre_idle", 32'(busy_b), 32'd0);
    addr_b = {4'hC, 4'h0, 4'hA, 4'h0}; req_b = 4'b1010;
    push_b(8'h08, 4'hC, 0);
    push_b(8'h02, 4'hA, 6);
    tick();
    chk("t3_grant_core3", 32'(grant_b),   32'h8);
    chk("t3_l2_addr",     32'(l2_addr_b), 32'hC);
    tick(6);
    chk("t3_grant_core1", 32'(grant_b),   32'h2);
    chk("t3_l2_addr2",    32'(l2_addr_b), 32'hA);
    req_b = 4'b0000;
    tick(6);

    // drain: every expected response must have appeared
    for (int i = 0; i < 30 && (qa.size() != 0 || qb.size() != 0); i++) tick();
    chk("drain_pending", 32'(qa.size() + qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, meaning number of requesting cores (legal range 2..8).
REQ-002 SHALL have parameter TAG_WIDTH, default 4, meaning L2 address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, meaning L2 data width.
REQ-004 SHALL have parameter L2_LATENCY, default 1, meaning cycles from l2_en to valid l2_data (legal range 1..15).
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port req, input, NUM_CORES bits: per-core bus request.
REQ-008 SHALL have port addr, input, NUM_CORES*TAG_WIDTH bits: core i address at bits [i*TAG_WIDTH +: TAG_WIDTH].
REQ-009 SHALL have port grant, output, NUM_CORES bits: one-hot grant, held for the whole transaction.
REQ-010 SHALL have port l2_en, output, 1 bit: L2 read strobe.
REQ-011 SHALL have port l2_addr, output, TAG_WIDTH bits: L2 read address.
REQ-012 SHALL have port l2_data, input, DATA_WIDTH bits: L2 read data.
REQ-013 SHALL have port l2_hit, input, 1 bit: L2 hit flag, valid with l2_data.
REQ-014 SHALL have port rsp_valid, output, NUM_CORES bits: one-hot one-cycle response strobe.
REQ-015 SHALL have port rsp_data, output, DATA_WIDTH bits: response data, shared by all cores.
REQ-016 SHALL have port rsp_hit, output, 1 bit: registered l2_hit for the response.
REQ-017 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; transitions IDLE->ISSUE when any req is high; ISSUE->WAIT always; WAIT->RESP after exactly L2_LATENCY WAIT cycles; RESP->IDLE always.
REQ-019 SHALL choose, in IDLE, the first requesting core at or after rr_ptr (modulo NUM_CORES) and register its one-hot grant and its addr on the edge entering ISSUE.
REQ-020 SHALL drive l2_en=1 for exactly the ISSUE cycle, with l2_addr equal to the captured address; l2_addr SHALL hold that value until RESP ends.
REQ-021 SHALL sample l2_data and l2_hit at the clock edge that ends the last WAIT cycle.
REQ-022 SHALL pulse rsp_valid[g] for exactly the RESP cycle, with rsp_data and rsp_hit holding the sampled values until the next capture.
REQ-023 SHALL place the req-sampled-in-IDLE edge at cycle 0, making grant visible at cycle 1 and rsp_valid at cycle 2+L2_LATENCY; back-to-back transactions SHALL therefore occupy 3+L2_LATENCY cycles each.
REQ-024 SHALL deassert grant on the edge leaving RESP and set rr_ptr to (g+1) mod NUM_CORES on that edge.
REQ-025 SHALL ignore req and addr changes between ISSUE and RESP; a req dropped mid-transaction SHALL still complete with rsp_valid.
REQ-026 SHALL resolve simultaneous requests purely by rr_ptr order; a continuously requesting core SHALL wait at most NUM_CORES-1 transactions.
REQ-027 SHALL never assert more than one bit of grant or rsp_valid.

Reset
REQ-028 SHALL, on reset high, immediately force: state IDLE, rr_ptr 0, grant 0, l2_en 0, l2_addr 0, rsp_valid 0, rsp_data 0, rsp_hit 0, busy 0.
REQ-029 SHALL abort any in-flight transaction on reset without issuing rsp_valid; the first arbitration after reset SHALL start from core 0.

Configuration
REQ-030 SHALL, when L2_ARB_STATS_EN is defined, add outputs txn_count[15:0] (incremented per RESP) and miss_count[15:0] (incremented per RESP with l2_hit=0), both saturating at 16'hFFFF and reset to 0.
REQ-031 SHALL, when L2_ARB_STATS_EN is undefined, omit both ports and counters, leaving all other behaviour identical.

Structure
REQ-032 SHALL take the state encoding (2-bit localparams), the clog2 helper and the default parameter constants from shared package l2_arb_pkg.
REQ-033 SHALL place round-robin selection in combinational sub-module rr_pick (inputs req and rr_ptr, output one-hot pick).

Verification
REQ-034 SHALL cover: NUM_CORES=2, L2_LATENCY=1, req=01, addr0=4'h3, l2_data=8'hA5 -> grant=01 at cycle 1, l2_addr=3 with l2_en at cycle 1, rsp_valid=01 with rsp_data=A5 at cycle 3.
REQ-035 SHALL cover: req=11 held constantly -> grants alternate 01,10,01 on successive transactions, each 4 cycles long.
REQ-036 SHALL cover: NUM_CORES=4, L2_LATENCY=3, req=1010 after rr_ptr=2 -> core 3 granted first, then core 1; rsp_valid 5 cycles after each grant-sampling cycle.
REQ-037 SHALL cover: reset asserted during WAIT -> all outputs 0 in the same cycle, no rsp_valid, and the next req=11 grants core 0.
REQ-038 SHALL cover: core 0 drops req and changes addr during WAIT -> l2_addr unchanged and rsp_valid=01 still issued.
REQ-039 SHALL cover, with L2_ARB_STATS_EN: 3 transactions with l2_hit=1,0,0 -> txn_count=3, miss_count=2.
